// File: rtl/rsa_pkg.sv
// Shared types for the modular exponentiation datapath.
package rsa_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT = 32;

  typedef logic [WORD_WIDTH_DEFAULT-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    STEP  = 3'd2,
    MUL   = 3'd3,
    TEST  = 3'd4,
    SQR   = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/rsa_modexp_if.sv
// start/done request bus for the modular exponentiation block.
interface rsa_modexp_if
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
);

  logic                  start;
  logic [WORD_WIDTH-1:0] base;
  logic [WORD_WIDTH-1:0] exponent;
  logic [WORD_WIDTH-1:0] modulus;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [WORD_WIDTH-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, error, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, error, result
  );

endinterface

// File: rtl/rsa_modexp_mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one bit of a per cycle.
module mod_mult #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [WORD_WIDTH-1:0] n,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] p
);

  localparam int unsigned ACC_W = WORD_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] a_q;
  logic [WORD_WIDTH-1:0] b_q;
  logic [WORD_WIDTH-1:0] n_q;
  logic [ACC_W-1:0]      acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  active_q;
  logic [ACC_W-1:0]      sum_c;
  logic [ACC_W-1:0]      red1_c;
  logic [ACC_W-1:0]      acc_c;

  // One iteration: double, add b for the current MSB of a, then reduce (acc < 3n so two subtracts suffice).
  always_comb begin
    sum_c  = (acc_q << 1) + (a_q[WORD_WIDTH-1] ? ACC_W'(b_q) : '0);
    red1_c = (sum_c >= ACC_W'(n_q)) ? (sum_c - ACC_W'(n_q)) : sum_c;
    acc_c  = (red1_c >= ACC_W'(n_q)) ? (red1_c - ACC_W'(n_q)) : red1_c;
  end

  // Operand latch, iteration counter and done pulse; start is ignored while active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active_q) begin
        acc_q <= acc_c;
        a_q   <= a_q << 1;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end else if (start) begin
        a_q      <= a;
        b_q      <= b;
        n_q      <= n;
        acc_q    <= '0;
        cnt_q    <= CNT_W'(WORD_WIDTH);
        active_q <= 1'b1;
      end
    end
  end

  assign p = acc_q[WORD_WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply modular exponentiation, one multiply in flight at a time.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  rsa_modexp_if.slave  bus
);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] b_q, b_d;
  logic [WORD_WIDTH-1:0] x_q, x_d;
  logic [WORD_WIDTH-1:0] n_q, n_d;
  logic [WORD_WIDTH-1:0] r_q, r_d;
  logic [WORD_WIDTH-1:0] result_q, result_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  mm_start_q, mm_start_d;
  logic [WORD_WIDTH-1:0] mm_a_c;
  logic                  mm_done;
  logic [WORD_WIDTH-1:0] mm_p;

  // Square uses b*b, multiply uses r*b.
  assign mm_a_c = (state_q == SQR) ? b_q : r_q;

  mod_mult #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_mod_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start_q),
    .a     (mm_a_c),
    .b     (b_q),
    .n     (n_q),
    .done  (mm_done),
    .p     (mm_p)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    x_d        = x_q;
    n_d        = n_q;
    r_d        = r_q;
    result_d   = result_q;
    error_d    = error_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mm_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          b_d     = bus.base;
          x_d     = bus.exponent;
          n_d     = bus.modulus;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Trivial outcomes are parked in r so DONE has a single result source.
        if ((n_q == '0) || (b_q >= n_q)) begin
          error_d = 1'b1;
          r_d     = '0;
          state_d = DONE;
        end else if (n_q == WORD_WIDTH'(1)) begin
          r_d     = '0;
          state_d = DONE;
        end else if (x_q == '0) begin
          r_d     = WORD_WIDTH'(1);
          state_d = DONE;
        end else begin
          r_d     = WORD_WIDTH'(1);
          state_d = STEP;
        end
      end
      STEP: begin
        if (x_q[0]) begin
          mm_start_d = 1'b1;
          state_d    = MUL;
        end else begin
          state_d = TEST;
        end
      end
      MUL: begin
        if (mm_done) begin
          r_d     = mm_p;
          state_d = TEST;
        end
      end
      TEST: begin
        if (x_q[WORD_WIDTH-1:1] == '0) begin
          state_d = DONE;
        end else begin
          mm_start_d = 1'b1;
          state_d    = SQR;
        end
      end
      SQR: begin
        if (mm_done) begin
          b_d     = mm_p;
          x_d     = x_q >> 1;
          state_d = STEP;
        end
      end
      DONE: begin
        result_d = r_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      x_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      x_q        <= x_d;
      n_q        <= n_d;
      r_q        <= r_d;
      result_q   <= result_d;
      error_q    <= error_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Computes result = base^exponent mod modulus with iterative right-to-left square-and-multiply.
- Sits directly downstream of key generation: takes N as modulus and e (encrypt) or d (decrypt) as exponent.
- Multiplies are done one at a time by a bit-serial interleaved modular multiplier sub-module.
- start/done handshake matches the other datapath blocks.

Parameters:
WORD_WIDTH, 32, width of base, exponent, modulus and result

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin operation; sampled only in IDLE
base  in  WORD_WIDTH  message/ciphertext; must be < modulus
exponent  in  WORD_WIDTH  e or d
modulus  in  WORD_WIDTH  N
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when result/error are valid
error  out  1  valid with done; sticky until next accepted start
result  out  WORD_WIDTH  held from done until next accepted start

Behaviour:
- Reset (any time, including mid-operation): state IDLE; busy=0, done=0, error=0, result=0; sub-module aborted.
- Reset clears all internal registers.
- IDLE: start=1 latches base, exponent, modulus into registers b, x, n; clears error; next state CHECK. Inputs are not used after this latch.
- start while busy is ignored.
- CHECK, one cycle:
  - n==0 or b>=n: error=1, result=0, go DONE.
  - n==1: result=0, go DONE.
  - x==0: result=1, go DONE.
  - otherwise r=1, go STEP.
- STEP: if x[0]==1, go MUL (r = r*b mod n); else go TEST.
- TEST: if (x>>1)==0, go DONE; else go SQR (b = b*b mod n).
- After SQR: x = x>>1, go STEP.
- MUL/SQR:
  - Pulse mm_start for one cycle with operands.
  - Wait for mm_done, then capture mm_result into r or b.
  - Only one multiply is in flight at a time.
- DONE: done=1 for exactly one cycle; result=r unless already set by CHECK; busy=0; next state IDLE.
- A new start is accepted in the cycle after done.
- Widths:
  - All stored values stay < n, so they fit in WORD_WIDTH.
  - The multiplier accumulator is WORD_WIDTH+2 bits, unsigned, no overflow.
- Latency:
  - Error or trivial cases: done 3 cycles after the start edge.
  - General case is bounded by 3 + L*(2*(WORD_WIDTH+2)+2), where L is the bit length of the exponent. The bench checks against this bound.

Decomposition:
- Package rsa_pkg:
  - state enum (IDLE, CHECK, STEP, MUL, TEST, SQR, DONE), 3 bits.
  - a word_t typedef parameterised by WORD_WIDTH, via the package's localparam default of 32.
- Sub-module mod_mult, interleaved modular multiplier.
  - Ports: clk, rst, start, a, b, n, done, p.
  - On start, latches a, b, n and sets acc=0.
  - For WORD_WIDTH cycles, MSB of a first: acc = 2*acc + (a_i ? b : 0), then subtract n up to twice while acc>=n.
  - done pulses the cycle after the last iteration; p = acc.
  - Requires a, b < n.
  - Reset aborts it; start while active is ignored.

Test Plan:
1. base=4, exponent=13, modulus=497 -> done with result=445, error=0; latency within bound.
2. RSA pair N=3233, e=17, d=2753:
   - base=65, exponent=17 -> result=2790.
   - Then base=2790, exponent=2753 -> result=65.
   - Both runs are back-to-back, start issued the cycle after done.
3. Trivial cases, each giving done at 3 cycles and error=0:
   - exponent=0, modulus=3233, base=123 -> result=1.
   - modulus=1 -> result=0.
4. Error cases, each giving error=1, result=0, done at 3 cycles:
   - modulus=0.
   - base=3233, modulus=3233.
   - Next valid start clears error.
5. Control and reset:
   - Start run 2's decrypt, then assert rst mid-SQR -> busy=0, done=0, result=0 immediately.
   - Rerunning after reset gives the correct 65.
   - Pulsing start while busy must not alter the result.
6. Random sweep with WORD_WIDTH=16: 1000 random (base<modulus, exponent, modulus>1) checked against a reference model -> all results match.
